// File: rtl/ctrl_op_feeder.sv
// ctrl_op_feeder: FIFO-buffered opcode stage that holds each op on dec_x until dec_ack.
// Define CTRL_FEEDER_PARITY_EN to add in_par checking and the par_err_cnt counter.
module ctrl_op_feeder #(
   parameter int DEPTH = 4,
   parameter int OP_W  = 7
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [OP_W-1:0] in_op,
   input  logic            flush,
   output logic [OP_W-1:0] dec_x,
   output logic            dec_valid,
   input  logic            dec_ack,
   output logic            empty,
   output logic            full,
`ifdef CTRL_FEEDER_PARITY_EN
   input  logic            in_par,
   output logic [7:0]      par_err_cnt,
`endif
   output logic [15:0]     issued_cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam int OW = AW + 1;
   typedef enum logic {IDLE, ISSUE} state_t;
   state_t state, state_nx;
   logic [OP_W-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [OW-1:0] occ;
   logic clr, push, wr_en, pop, adv;
   assign clr       = ~rst_n | flush;
   assign in_ready  = rst_n & ~flush & (occ < OW'(DEPTH));
   assign push      = in_valid & in_ready;
   assign empty     = occ == '0;
   assign full      = occ == OW'(DEPTH);
   assign dec_valid = state == ISSUE;
`ifdef CTRL_FEEDER_PARITY_EN
   logic par_bad;
   assign par_bad = push & ^{in_op, in_par};
   assign wr_en   = push & ~par_bad;
   always_ff @(posedge clk) begin
      if (!rst_n) par_err_cnt <= '0;
      else if (par_bad && par_err_cnt != 8'hFF) par_err_cnt <= par_err_cnt + 8'd1;
   end
`else
   assign wr_en = push;
`endif
   // The FSM sees only registered occupancy, so a push into an empty FIFO waits one edge.
   always_comb begin
      adv      = (state == IDLE) | dec_ack;
      pop      = ~clr & adv & ~empty;
      state_nx = adv ? (empty ? IDLE : ISSUE) : state;
   end
   always_ff @(posedge clk) begin
      state <= clr ? IDLE : state_nx;
   end
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= in_op;
   end
   always_ff @(posedge clk) begin
      if (clr) begin
         occ    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         occ <= occ + OW'(wr_en) - OW'(pop);
      end
   end
   // dec_x survives flush; only reset clears it.
   always_ff @(posedge clk) begin
      if (!rst_n) dec_x <= '0;
      else if (pop) dec_x <= mem[rd_ptr];
   end
   always_ff @(posedge clk) begin
      if (!rst_n) issued_cnt <= '0;
      else if (dec_valid && dec_ack && !flush) issued_cnt <= issued_cnt + 16'd1;
   end
endmodule

// File: tb/tb_ctrl_op_feeder.sv
// tb_ctrl_op_feeder: directed and randomized checks of ctrl_op_feeder against a queue-based model.
module tb_ctrl_op_feeder;
   localparam int DEPTH = 4;
   localparam int OP_W  = 7;
   logic clk = 0, rst_n = 0, in_valid = 0, flush = 0, dec_ack = 0;
   logic [OP_W-1:0] in_op = '0;
   logic in_ready, dec_valid, empty, full;
   logic [OP_W-1:0] dec_x;
   logic [15:0] issued_cnt;
`ifdef CTRL_FEEDER_PARITY_EN
   logic par_flip = 0;
   logic in_par;
   logic [7:0] par_err_cnt;
   logic [7:0] m_perr;
   assign in_par = ^in_op ^ par_flip;
`endif
   int errors = 0, checks = 0;
   logic [OP_W-1:0] q[$];
   logic [OP_W-1:0] m_x;
   logic m_v;
   logic [15:0] m_cnt;

   ctrl_op_feeder #(.DEPTH(DEPTH), .OP_W(OP_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .flush(flush), .dec_x(dec_x), .dec_valid(dec_valid), .dec_ack(dec_ack),
      .empty(empty), .full(full),
`ifdef CTRL_FEEDER_PARITY_EN
      .in_par(in_par), .par_err_cnt(par_err_cnt),
`endif
      .issued_cnt(issued_cnt));

   always #5 clk = ~clk;

   // Advance model and DUT by one edge; acceptance uses the pre-edge queue size.
   task automatic tick();
      bit acc = rst_n && !flush && in_valid && q.size() < DEPTH;
      logic [OP_W-1:0] op = in_op;
      bit good = 1;
`ifdef CTRL_FEEDER_PARITY_EN
      good = ~^{in_op, in_par};
      if (!rst_n) m_perr = 0;
      else if (acc && !good && m_perr != 8'hFF) m_perr++;
`endif
      if (!rst_n || flush) begin
         q.delete();
         m_v = 0;
         if (!rst_n) begin m_x = 0; m_cnt = 0; end
      end else begin
         if (m_v && dec_ack) m_cnt++;
         if (!m_v || dec_ack) begin
            if (q.size() > 0) begin m_x = q.pop_front(); m_v = 1; end
            else m_v = 0;
         end
         if (acc && good) q.push_back(op);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_flush();
      flush = 1; in_valid = 0; dec_ack = 0;
      tick();
      flush = 0;
   endtask

   task automatic test_reset();
      rst_n = 0;
      repeat (3) tick();
      checks++; if (dec_x !== '0) begin errors++; $display("FAIL reset_dec_x: got %h want 0", dec_x); end
      checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL reset_dec_valid: got %b want 0", dec_valid); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
      checks++; if (issued_cnt !== 16'd0) begin errors++; $display("FAIL reset_issued_cnt: got %h want 0", issued_cnt); end
`ifdef CTRL_FEEDER_PARITY_EN
      checks++; if (par_err_cnt !== 8'd0) begin errors++; $display("FAIL reset_par_err_cnt: got %h want 0", par_err_cnt); end
`endif
      rst_n = 1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_single();
      in_valid = 1; in_op = 7'h5A; dec_ack = 1;
      tick();
      in_valid = 0;
      checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL single_no_bypass: got %b want 0", dec_valid); end
      tick();
      checks++; if (dec_valid !== 1'b1 || dec_x !== 7'h5A) begin errors++; $display("FAIL single_issue: got v=%b x=%h want v=1 x=5a", dec_valid, dec_x); end
      tick();
      checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL single_retire: got %b want 0", dec_valid); end
      checks++; if (issued_cnt !== 16'd1) begin errors++; $display("FAIL single_cnt: got %0d want 1", issued_cnt); end
      dec_ack = 0;
   endtask

   task automatic test_fill();
      logic [OP_W-1:0] ops [6];
      for (int i = 0; i < 6; i++) ops[i] = 7'($urandom);
      do_flush();
      for (int i = 0; i < 5; i++) begin
         in_valid = 1; in_op = ops[i];
         #1;
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_%0d: got %b want 1", i, in_ready); end
         tick();
      end
      in_op = ops[5];
      #1;
      checks++; if (full !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL fill_full: got full=%b rdy=%b want 1/0", full, in_ready); end
      checks++; if (dec_valid !== 1'b1 || dec_x !== ops[0]) begin errors++; $display("FAIL fill_head: got v=%b x=%h want 1/%h", dec_valid, dec_x, ops[0]); end
      repeat (2) tick();
      checks++; if (full !== 1'b1 || dec_x !== ops[0]) begin errors++; $display("FAIL fill_stall: got full=%b x=%h want 1/%h", full, dec_x, ops[0]); end
      dec_ack = 1;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_pop_no_push: got %b want 0", in_ready); end
      tick();
      dec_ack = 0;
      checks++; if (dec_x !== ops[1] || full !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL fill_after_ack: got x=%h full=%b rdy=%b want %h/0/1", dec_x, full, in_ready, ops[1]); end
      tick();
      in_valid = 0;
      checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_refill: got %b want 1", full); end
   endtask

   task automatic test_back_to_back();
      logic [OP_W-1:0] b [5];
      logic [15:0] c0;
      for (int i = 0; i < 5; i++) b[i] = 7'($urandom);
      do_flush();
      for (int i = 0; i < 5; i++) begin in_valid = 1; in_op = b[i]; tick(); end
      in_valid = 0;
      c0 = issued_cnt;
      dec_ack = 1;
      for (int i = 1; i < 5; i++) begin
         tick();
         checks++; if (dec_valid !== 1'b1 || dec_x !== b[i]) begin errors++; $display("FAIL b2b_step_%0d: got v=%b x=%h want 1/%h", i, dec_valid, dec_x, b[i]); end
      end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL b2b_empty: got %b want 1", empty); end
      tick();
      dec_ack = 0;
      checks++; if (dec_valid !== 1'b0 || issued_cnt !== c0 + 16'd5) begin errors++; $display("FAIL b2b_done: got v=%b cnt=%0d want 0/%0d", dec_valid, issued_cnt, c0 + 16'd5); end
   endtask

   task automatic test_flush();
      logic [OP_W-1:0] f [4];
      logic [15:0] c0;
      for (int i = 0; i < 4; i++) f[i] = 7'($urandom);
      do_flush();
      for (int i = 0; i < 4; i++) begin in_valid = 1; in_op = f[i]; tick(); end
      c0 = issued_cnt;
      checks++; if (dec_valid !== 1'b1 || empty !== 1'b0) begin errors++; $display("FAIL flush_pre: got v=%b empty=%b want 1/0", dec_valid, empty); end
      flush = 1; dec_ack = 1; in_valid = 1; in_op = 7'($urandom);
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
      tick();
      flush = 0; dec_ack = 0; in_valid = 0;
      checks++; if (dec_valid !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL flush_clear: got v=%b empty=%b want 0/1", dec_valid, empty); end
      checks++; if (issued_cnt !== c0) begin errors++; $display("FAIL flush_cnt: got %0d want %0d", issued_cnt, c0); end
      checks++; if (dec_x !== f[0]) begin errors++; $display("FAIL flush_dec_x: got %h want %h", dec_x, f[0]); end
      tick();
      checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL flush_stays_idle: got %b want 0", dec_valid); end
   endtask

`ifdef CTRL_FEEDER_PARITY_EN
   task automatic test_parity();
      logic [7:0] p0;
      do_flush();
      p0 = par_err_cnt;
      in_valid = 1; in_op = 7'h01; par_flip = 1;
      tick();
      in_valid = 0; par_flip = 0;
      tick();
      checks++; if (par_err_cnt !== p0 + 8'd1) begin errors++; $display("FAIL par_bad_cnt: got %0d want %0d", par_err_cnt, p0 + 8'd1); end
      checks++; if (dec_valid !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL par_bad_dropped: got v=%b empty=%b want 0/1", dec_valid, empty); end
      in_valid = 1; in_op = 7'h01;
      tick();
      in_valid = 0;
      tick();
      checks++; if (dec_valid !== 1'b1 || dec_x !== 7'h01) begin errors++; $display("FAIL par_good_issue: got v=%b x=%h want 1/01", dec_valid, dec_x); end
   endtask
`endif

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         in_op    = 7'($urandom);
         dec_ack  = $urandom_range(0, 3) != 0;
         flush    = $urandom_range(0, 31) == 0;
         rst_n    = $urandom_range(0, 79) != 0;
`ifdef CTRL_FEEDER_PARITY_EN
         par_flip = $urandom_range(0, 7) == 0;
`endif
         #1;
         checks++; if (in_ready !== (rst_n && !flush && q.size() < DEPTH)) begin errors++; $display("FAIL rnd_in_ready@%0d: got %b want %b", i, in_ready, rst_n && !flush && q.size() < DEPTH); end
         tick();
         checks++; if (dec_valid !== m_v || dec_x !== m_x) begin errors++; $display("FAIL rnd_dec@%0d: got v=%b x=%h want %b/%h", i, dec_valid, dec_x, m_v, m_x); end
         checks++; if (empty !== (q.size() == 0) || full !== (q.size() == DEPTH)) begin errors++; $display("FAIL rnd_flags@%0d: got e=%b f=%b want occ=%0d", i, empty, full, q.size()); end
         checks++; if (issued_cnt !== m_cnt) begin errors++; $display("FAIL rnd_cnt@%0d: got %0d want %0d", i, issued_cnt, m_cnt); end
`ifdef CTRL_FEEDER_PARITY_EN
         checks++; if (par_err_cnt !== m_perr) begin errors++; $display("FAIL rnd_par_cnt@%0d: got %0d want %0d", i, par_err_cnt, m_perr); end
`endif
      end
      rst_n = 1; flush = 0; in_valid = 0; dec_ack = 0;
`ifdef CTRL_FEEDER_PARITY_EN
      par_flip = 0;
`endif
   endtask

   task automatic test_cnt_wrap();
      logic [15:0] prev;
      bit wrapped = 0;
      do_flush();
      in_valid = 1; dec_ack = 1;
      for (int i = 0; i < 70000 && !wrapped; i++) begin
         in_op = 7'($urandom);
         prev = m_cnt;
         tick();
         if (prev == 16'hFFFF && m_cnt == 16'h0000) begin
            wrapped = 1;
            checks++; if (issued_cnt !== 16'h0000) begin errors++; $display("FAIL cnt_wrap: got %h want 0000", issued_cnt); end
         end else if (prev == 16'hFFFE && m_cnt == 16'hFFFF) begin
            checks++; if (issued_cnt !== 16'hFFFF) begin errors++; $display("FAIL cnt_max: got %h want ffff", issued_cnt); end
         end
      end
      checks++; if (!wrapped) begin errors++; $display("FAIL cnt_wrap_timeout: got no wrap want wrap within 70000 cycles"); end
      in_valid = 0; dec_ack = 0;
   endtask

   initial begin
      m_x = 0; m_v = 0; m_cnt = 0;
`ifdef CTRL_FEEDER_PARITY_EN
      m_perr = 0;
`endif
      test_reset();
      test_single();
      test_fill();
      test_back_to_back();
      test_flush();
`ifdef CTRL_FEEDER_PARITY_EN
      test_parity();
`endif
      test_random();
      test_cnt_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
